// File: rtl/mult_lab_pkg.sv
// mult_lab_pkg: shared state encoding, mode constants and default sizes for the multiplier lab
package mult_lab_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, CHECK, NEXT, DONE} state_t;
  localparam logic MODE_PAIRED = 1'b0;
  localparam logic MODE_SWEEP = 1'b1;
  localparam int DEF_W = 4;
  localparam int DEF_DEPTH = 16;
endpackage

// File: rtl/mult_operands_rom_p.sv
// mult_operands_rom_p: 2*DEPTH x W dual-read ROM (multiplicands then multipliers), registered outputs
module mult_operands_rom_p #(
  parameter int W = 4,
  parameter int DEPTH = 16,
  localparam int RAW = $clog2(DEPTH) + 1
)(
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [RAW-1:0] addr_a,
  input  logic [RAW-1:0] addr_b,
  output logic [W-1:0]   q_a,
  output logic [W-1:0]   q_b
);
  function automatic logic [W-1:0] word(input logic [RAW-1:0] addr);
    return W'(int'(addr) >= DEPTH ? int'(addr) - DEPTH : int'(addr));
  endfunction
  always_ff @(posedge clk)
    if (reset) begin
      q_a <= '0;
      q_b <= '0;
    end else if (en) begin
      q_a <= word(addr_a);
      q_b <= word(addr_b);
    end
endmodule

// File: rtl/mult_operand_sequencer.sv
// mult_operand_sequencer: issues ROM operand pairs to a multiplier over valid/ready and checks products
module mult_operand_sequencer
  import mult_lab_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ECW = 8
)(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           mode,
  output logic [W-1:0]   op_a,
  output logic [W-1:0]   op_b,
  output logic           op_valid,
  input  logic           op_ready,
  input  logic [2*W-1:0] res,
  input  logic           res_valid,
  output logic           busy,
  output logic           done,
  output logic [ECW-1:0] err_count,
  output logic [W-1:0]   last_a,
  output logic [W-1:0]   last_b,
  output logic [2*W-1:0] last_res
);
  localparam int AW = $clog2(DEPTH);
  localparam int RAW = AW + 1;
  state_t state;
  logic mode_q;
  logic [AW-1:0] i, j;
  logic [2*W-1:0] res_q, exp_p;
  logic [RAW-1:0] addr_a, addr_b;
  logic i_last, j_last;
  assign addr_a = RAW'(i);
  assign addr_b = RAW'(DEPTH) + RAW'(mode_q ? j : i);
  assign exp_p = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
  assign i_last = i == AW'(DEPTH - 1);
  assign j_last = j == AW'(DEPTH - 1);
  mult_operands_rom_p #(.W(W), .DEPTH(DEPTH)) rom (
    .clk(clk),
    .reset(reset),
    .en(state == FETCH),
    .addr_a(addr_a),
    .addr_b(addr_b),
    .q_a(op_a),
    .q_b(op_b)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      mode_q <= MODE_PAIRED;
      i <= '0;
      j <= '0;
      op_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err_count <= '0;
      res_q <= '0;
      last_a <= '0;
      last_b <= '0;
      last_res <= '0;
    end else
      case (state)
        IDLE, DONE:
          if (start) begin
            state <= FETCH;
            mode_q <= mode;
            i <= '0;
            j <= '0;
            err_count <= '0;
            done <= 1'b0;
            busy <= 1'b1;
          end
        FETCH: begin
          state <= ISSUE;
          op_valid <= 1'b1;
        end
        ISSUE:
          if (op_ready) begin
            state <= WAIT;
            op_valid <= 1'b0;
          end
        WAIT:
          if (res_valid) begin
            state <= CHECK;
            res_q <= res;
          end
        CHECK: begin
          if (res_q != exp_p && err_count != '1) err_count <= err_count + ECW'(1);
          last_a <= op_a;
          last_b <= op_b;
          last_res <= res_q;
          state <= NEXT;
        end
        NEXT:
          if (mode_q == MODE_SWEEP && !j_last) begin
            j <= j + AW'(1);
            state <= FETCH;
          end else if (i_last) begin
            state <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            i <= i + AW'(1);
            j <= '0;
            state <= FETCH;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mult_operand_sequencer.sv
// tb_mult_operand_sequencer: directed self-checking bench for mult_operand_sequencer
module tb_mult_operand_sequencer;
  import mult_lab_pkg::*;
  logic clk = 1'b0;
  logic reset, start, mode, op_ready, fault, sp_rv;
  logic [3:0] op_a, op_b, last_a, last_b;
  logic [7:0] res, last_res, mdl_res;
  logic op_valid, res_valid, busy, done, mdl_rv;
  logic [7:0] err_count;
  logic start2, mode2, op_valid2, busy2, done2, rv2, pend2;
  logic [7:0] op_a2, op_b2, last_a2, last_b2, err2;
  logic [15:0] last_res2, r2, p2;
  int n_vec = 0;
  int n_err = 0;
  int hs = 0;
  int hs2 = 0;
  always #5 clk = ~clk;
  assign res = sp_rv ? 8'hFF : mdl_res;
  assign res_valid = mdl_rv | sp_rv;
  mult_operand_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .res(res), .res_valid(res_valid), .busy(busy), .done(done),
    .err_count(err_count), .last_a(last_a), .last_b(last_b), .last_res(last_res)
  );
  mult_operand_sequencer #(.W(8), .DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .mode(mode2),
    .op_a(op_a2), .op_b(op_b2), .op_valid(op_valid2), .op_ready(1'b1),
    .res(r2), .res_valid(rv2), .busy(busy2), .done(done2),
    .err_count(err2), .last_a(last_a2), .last_b(last_b2), .last_res(last_res2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  initial begin
    int ea, eb, pend;
    logic msweep;
    logic [7:0] pres;
    ea = 0;
    eb = 0;
    pend = 0;
    msweep = 1'b0;
    pres = '0;
    mdl_rv = 1'b0;
    mdl_res = '0;
    forever begin
      @(negedge clk);
      mdl_rv = 1'b0;
      if (reset) pend = 0;
      else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            mdl_rv = 1'b1;
            mdl_res = pres;
          end
        end
        if (start && !busy) begin
          ea = 0;
          eb = 0;
          hs = 0;
          msweep = mode;
        end
        if (op_valid && op_ready) begin
          chk("hs_a", op_a, ea);
          chk("hs_b", op_b, eb);
          hs++;
          pres = 8'(op_a) * 8'(op_b) ^ 8'(fault && op_a == 4'd3);
          pend = 3;
          if (!msweep) begin
            ea++;
            eb++;
          end else if (eb == 15) begin
            eb = 0;
            ea++;
          end else eb++;
        end
      end
    end
  end
  initial begin
    rv2 = 1'b0;
    r2 = '0;
    pend2 = 1'b0;
    p2 = '0;
    forever begin
      @(negedge clk);
      rv2 = pend2;
      r2 = p2;
      pend2 = op_valid2 && !reset;
      p2 = 16'(op_a2) * 16'(op_b2);
      if (start2 && !busy2) hs2 = 0;
      if (op_valid2 && !reset) hs2++;
    end
  end
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input int max);
    int k = 0;
    while (!done && k < max) begin
      @(posedge clk);
      #1 k++;
    end
    chk("done", done, 1);
  endtask
  initial begin
    int k;
    reset = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    op_ready = 1'b1;
    fault = 1'b0;
    sp_rv = 1'b0;
    start2 = 1'b0;
    mode2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("idle_valid", op_valid, 0);
      @(posedge clk);
      #1;
    end
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_count, 0);
    chk("rst_last_a", last_a, 0);
    chk("rst_last_b", last_b, 0);
    chk("rst_last_res", last_res, 0);
    mode = 1'b0;
    pulse_start();
    chk("run_busy", busy, 1);
    wait_done(1000);
    chk("pair_busy", busy, 0);
    chk("pair_err", err_count, 0);
    chk("pair_hs", hs, 16);
    chk("pair_last_a", last_a, 15);
    chk("pair_last_b", last_b, 15);
    chk("pair_last_res", last_res, 225);
    mode = 1'b1;
    pulse_start();
    mode = 1'b0;
    wait_done(4000);
    chk("sweep_err", err_count, 0);
    chk("sweep_hs", hs, 256);
    chk("sweep_last_res", last_res, 225);
    fault = 1'b1;
    mode = 1'b1;
    pulse_start();
    wait_done(4000);
    fault = 1'b0;
    chk("fault_err", err_count, 16);
    chk("fault_hs", hs, 256);
    chk("fault_done_held", done, 1);
    op_ready = 1'b0;
    mode = 1'b0;
    pulse_start();
    k = 0;
    while (!op_valid && k < 20) begin
      @(posedge clk);
      #1 k++;
    end
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", op_valid, 1);
      chk("stall_a", op_a, 0);
      chk("stall_b", op_b, 0);
      sp_rv = c == 1;
      start = c == 3;
      mode = c == 3;
      @(posedge clk);
      #1;
    end
    sp_rv = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    op_ready = 1'b1;
    wait_done(1000);
    chk("stall_err", err_count, 0);
    chk("stall_hs", hs, 16);
    mode = 1'b1;
    pulse_start();
    k = 0;
    while (!(hs >= 3 && dut.state == WAIT) && k < 200) begin
      @(posedge clk);
      #1 k++;
    end
    chk("reach_wait", dut.state == WAIT, 1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_valid", op_valid, 0);
    chk("mid_rst_last_res", last_res, 0);
    mode = 1'b0;
    pulse_start();
    wait_done(1000);
    chk("restart_err", err_count, 0);
    chk("restart_hs", hs, 16);
    mode2 = 1'b1;
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    k = 0;
    while (!done2 && k < 500) begin
      @(posedge clk);
      #1 k++;
    end
    chk("w8_done", done2, 1);
    chk("w8_hs", hs2, 16);
    chk("w8_err", err2, 0);
    chk("w8_last_a", last_a2, 3);
    chk("w8_last_b", last_b2, 3);
    chk("w8_last_res", last_res2, 9);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
